// File: rtl/arb_pkg.sv
// Shared types and constants for the SDRAM arbiter.
package arb_pkg;

    localparam int NUM_REQ_DEFAULT = 4;
    localparam logic [31:0] WORD_INVALID = 32'hFFFF_FFFF;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        RELEASE = 2'd3
    } arb_state_e;

    // Width needed to hold an index in the range [0, n-1]; never below one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sdram_arbiter_rr_picker.sv
// Combinational round-robin picker: scans the request vector starting at
// ptr_i, wrapping modulo NUM_REQ, and returns the first active index.
module rr_picker
    import arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEFAULT,
    parameter int IW      = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      ptr_i,
    output logic [IW-1:0]      grant_o,
    output logic               valid_o
);

    // First active requester at or after ptr_i, in circular order.
    always_comb begin
        int          idx;
        logic [IW-1:0] idx_v;
        logic        found;
        grant_o = '0;
        valid_o = 1'b0;
        found   = 1'b0;
        idx     = 0;
        idx_v   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx   = (int'(ptr_i) + k) % NUM_REQ;
            idx_v = IW'(idx);
            if (!found && req_i[idx_v]) begin
                found   = 1'b1;
                grant_o = idx_v;
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM port between NUM_REQ masters.
// One transaction is outstanding at a time. Optional read watchdog is
// compiled in with the ARB_TIMEOUT_EN macro (TIMEOUT_CYCLES sets its limit).
//
// Handshake: a requester holds read or write high until it is served. A write
// is accepted in the cycle its slave_waitrequest bit is low; a read is served
// in the cycle its slave_readdatavalid bit is high. On the SDRAM side a strobe
// is accepted in any cycle where it is high and master_waitrequest is low.
module sdram_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_REQ        = NUM_REQ_DEFAULT,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int IW            = idx_w(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    slave_read,
    input  logic [NUM_REQ-1:0]    slave_write,
    input  logic [NUM_REQ*32-1:0] slave_address,
    input  logic [NUM_REQ*32-1:0] slave_writedata,
    output logic [NUM_REQ-1:0]    slave_waitrequest,
    output logic [NUM_REQ-1:0]    slave_readdatavalid,
    output logic [31:0]           slave_readdata,
    input  logic                  master_waitrequest,
    output logic [31:0]           master_address,
    output logic                  master_read,
    output logic                  master_write,
    output logic [31:0]           master_writedata,
    input  logic [31:0]           master_readdata,
    input  logic                  master_readdatavalid,
    output logic                  timeout_err,
    output arb_state_e            dbg_state_o,
    output logic [IW-1:0]         dbg_ptr_o,
    output logic [IW-1:0]         dbg_grant_o
);

    arb_state_e    state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] g_q, g_d;
    logic [IW-1:0] pick;
    logic          pick_valid;
    logic          rdv_eff;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = idx_w(TIMEOUT_CYCLES);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          drop_q, drop_d;
    logic          terr_q, terr_d;
`endif

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_picker (
        .req_i   (slave_read | slave_write),
        .ptr_i   (ptr_q),
        .grant_o (pick),
        .valid_o (pick_valid)
    );

    // Next-state and output decode; every output parks at its idle value first.
    always_comb begin
        state_d             = state_q;
        ptr_d               = ptr_q;
        g_d                 = g_q;
        slave_waitrequest   = '1;
        slave_readdatavalid = '0;
        slave_readdata      = master_readdata;
        master_address      = WORD_INVALID;
        master_writedata    = WORD_INVALID;
        master_read         = 1'b0;
        master_write        = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_d  = cnt_q;
        drop_d = drop_q;
        terr_d = terr_q;
        // A response owed to a timed-out read is swallowed wherever it lands.
        if (master_readdatavalid && drop_q) begin
            drop_d = 1'b0;
        end
        rdv_eff = master_readdatavalid && !drop_q;
`else
        rdv_eff = master_readdatavalid;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    g_d     = pick;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                master_address   = slave_address[int'(g_q)*32 +: 32];
                master_writedata = slave_writedata[int'(g_q)*32 +: 32];
                master_write     = slave_write[g_q];
                master_read      = slave_read[g_q] & ~slave_write[g_q];
                if (!slave_read[g_q] && !slave_write[g_q]) begin
                    // Requester gave up before being served.
                    state_d = RELEASE;
                end else if (!master_waitrequest) begin
                    if (slave_write[g_q]) begin
                        slave_waitrequest[g_q] = 1'b0;
                        state_d                = RELEASE;
                    end else begin
`ifdef ARB_TIMEOUT_EN
                        cnt_d = '0;
`endif
                        state_d = WAIT_RD;
                    end
                end
            end
            WAIT_RD: begin
                if (rdv_eff) begin
                    slave_readdatavalid[g_q] = 1'b1;
                    state_d                  = RELEASE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    slave_readdatavalid[g_q] = 1'b1;
                    slave_readdata           = WORD_INVALID;
                    terr_d                   = 1'b1;
                    drop_d                   = 1'b1;
                    state_d                  = RELEASE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
            RELEASE: begin
                ptr_d   = (g_q == IW'(NUM_REQ - 1)) ? '0 : g_q + IW'(1);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset that aborts any transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            g_q     <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= '0;
            drop_q  <= 1'b0;
            terr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            g_q     <= g_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
            terr_q  <= terr_d;
`endif
        end
    end

`ifdef ARB_TIMEOUT_EN
    assign timeout_err = terr_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout_err    = 1'b0;
`endif

    assign dbg_state_o = state_q;
    assign dbg_ptr_o   = ptr_q;
    assign dbg_grant_o = g_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: SDRAM responder model, per-cycle
// monitor with access/read-data scoreboards, table of single transactions and
// directed multi-cycle sequences.
module tb_sdram_arbiter;
    import arb_pkg::*;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    slave_read, slave_write;
    logic [N*32-1:0] slave_address, slave_writedata;
    logic [N-1:0]    slave_waitrequest, slave_readdatavalid;
    logic [31:0]     slave_readdata;
    logic            master_waitrequest;
    logic [31:0]     master_address, master_writedata, master_readdata;
    logic            master_read, master_write, master_readdatavalid;
    logic            timeout_err;
    arb_state_e      dbg_state;
    logic [1:0]      dbg_ptr, dbg_grant;

    int checks   = 0;
    int failures = 0;
    int acc_cnt  = 0;
    int cyc      = 0;
    int rd_lat   = 1;
    bit mon_en   = 1'b0;

    // acc_q: {idx[2], wr, addr[32], wdata[32]}; exp_q: {idx[2], data[32]}.
    logic [66:0] acc_q[$];
    logic [33:0] exp_q[$];
    logic [63:0] rsp_q[$];

    typedef struct {
        int          idx;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          stall;
        int          lat;
        int          exp_ptr;
    } vec_t;

    vec_t tbl[6];

    sdram_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .slave_read           (slave_read),
        .slave_write          (slave_write),
        .slave_address        (slave_address),
        .slave_writedata      (slave_writedata),
        .slave_waitrequest    (slave_waitrequest),
        .slave_readdatavalid  (slave_readdatavalid),
        .slave_readdata       (slave_readdata),
        .master_waitrequest   (master_waitrequest),
        .master_address       (master_address),
        .master_read          (master_read),
        .master_write         (master_write),
        .master_writedata     (master_writedata),
        .master_readdata      (master_readdata),
        .master_readdatavalid (master_readdatavalid),
        .timeout_err          (timeout_err),
        .dbg_state_o          (dbg_state),
        .dbg_ptr_o            (dbg_ptr),
        .dbg_grant_o          (dbg_grant)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=event required=none", name);
    endtask

    function automatic logic [31:0] model_data(input logic [31:0] a);
        return (a >> 4) + 32'h1A;
    endfunction

    function automatic logic [31:0] addr_of(input int i);
        return 32'h1000 + 32'(i) * 32'h10;
    endfunction

    task automatic push_acc(input int idx, input bit wr, input logic [31:0] a, input logic [31:0] d);
        logic [1:0] ix;
        ix = idx[1:0];
        acc_q.push_back({ix, wr, a, d});
    endtask

    task automatic push_exp(input int idx, input logic [31:0] d);
        logic [1:0] ix;
        ix = idx[1:0];
        exp_q.push_back({ix, d});
    endtask

    // SDRAM model: each accepted read returns model_data(addr) lat cycles later.
    logic        acc_now;
    logic [31:0] acc_addr;
    logic [63:0] rsp_e;
    always @(posedge clk) begin
        acc_now  = master_read && !master_waitrequest;
        acc_addr = master_address;
        cyc++;
        #1;
        master_readdatavalid = 1'b0;
        master_readdata      = $urandom;
        if (acc_now) rsp_q.push_back({32'(cyc + rd_lat - 1), model_data(acc_addr)});
        if (rsp_q.size() > 0 && rsp_q[0][63:32] == 32'(cyc)) begin
            rsp_e                = rsp_q.pop_front();
            master_readdatavalid = 1'b1;
            master_readdata      = rsp_e[31:0];
        end
    end

    // Monitor: every cycle, SDRAM accesses and read returns against the scoreboards.
    logic [66:0] mon_e;
    logic [33:0] mon_r;
    logic [3:0]  mon_w;
    always @(negedge clk) begin
        if (mon_en) begin
            chk("no_overlap", {63'd0, master_read && master_write}, 64'd0);
            if ((master_read || master_write) && !master_waitrequest) begin
                acc_cnt++;
                if (acc_q.size() == 0) begin
                    flag_fail("acc_unexpected");
                end else begin
                    mon_e = acc_q.pop_front();
                    chk("acc_grant", dbg_grant, mon_e[66:65]);
                    chk("acc_addr", master_address, mon_e[63:32]);
                    chk("acc_write", master_write, mon_e[64]);
                    chk("acc_read", master_read, !mon_e[64]);
                    if (mon_e[64]) chk("acc_wdata", master_writedata, mon_e[31:0]);
                    mon_w = 4'b0001 << mon_e[66:65];
                    mon_w = mon_e[64] ? ~mon_w : 4'hF;
                    chk("acc_waitreq", slave_waitrequest, mon_w);
                end
            end else begin
                chk("hold_waitreq", slave_waitrequest, 4'hF);
                if (!master_read && !master_write) begin
                    chk("idle_addr", master_address, 32'hFFFF_FFFF);
                    chk("idle_wdata", master_writedata, 32'hFFFF_FFFF);
                end
            end
            if (slave_readdatavalid != '0) begin
                if (exp_q.size() == 0) begin
                    flag_fail("rdv_unexpected");
                end else begin
                    mon_r = exp_q.pop_front();
                    mon_w = 4'b0001 << mon_r[33:32];
                    chk("rdv_onehot", slave_readdatavalid, mon_w);
                    chk("rdv_data", slave_readdata, mon_r[31:0]);
                end
            end
        end
    end

    // One requester, one transaction, optional SDRAM stall before acceptance.
    task automatic run_txn(input vec_t v);
        int n_stall = 0;
        bit done    = 1'b0;
        int a0;
        rd_lat = v.lat;
        slave_address[v.idx*32 +: 32]   = v.addr;
        slave_writedata[v.idx*32 +: 32] = v.wdata;
        push_acc(v.idx, v.wr, v.addr, v.wdata);
        if (v.wr) slave_write[v.idx] = 1'b1;
        else begin
            slave_read[v.idx] = 1'b1;
            push_exp(v.idx, model_data(v.addr));
        end
        master_waitrequest = (v.stall > 0);
        a0 = acc_cnt;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (v.wr && !slave_waitrequest[v.idx]) done = 1'b1;
            if (!v.wr && slave_readdatavalid[v.idx]) done = 1'b1;
            if ((master_read || master_write) && master_waitrequest) n_stall++;
            @(posedge clk); #1;
            master_waitrequest = (n_stall < v.stall);
        end
        if (!done) flag_fail("txn_timeout");
        slave_read         = '0;
        slave_write        = '0;
        master_waitrequest = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("txn_acc_count", 64'(acc_cnt - a0), 64'd1);
    endtask

    // Several readers held high together; cN = number of reads per requester.
    task automatic run_multi(input int c0, input int c1, input int c2, input int c3, input int lat);
        int left[N];
        int busy;
        left[0] = c0; left[1] = c1; left[2] = c2; left[3] = c3;
        rd_lat = lat;
        master_waitrequest = 1'b0;
        for (int i = 0; i < N; i++) begin
            slave_address[i*32 +: 32] = addr_of(i);
            slave_read[i] = (left[i] > 0);
        end
        busy = 1;
        for (int c = 0; c < 400 && busy != 0; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) if (slave_readdatavalid[i] && left[i] > 0) left[i]--;
            @(posedge clk); #1;
            busy = 0;
            for (int i = 0; i < N; i++) begin
                if (left[i] == 0) slave_read[i] = 1'b0;
                busy += left[i];
            end
        end
        if (busy != 0) flag_fail("multi_timeout");
        slave_read = '0;
        repeat (2) begin @(posedge clk); #1; end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wcnt;
        bit hit;
        tbl[0] = '{2, 1'b0, 32'h0000_0100, 32'h0,          0, 3, 3};
        tbl[1] = '{1, 1'b1, 32'h0000_0040, 32'h0000_0005, 4, 1, 2};
        tbl[2] = '{0, 1'b0, 32'h0000_0008, 32'h0,          1, 1, 1};
        tbl[3] = '{3, 1'b1, 32'h000A_BCD0, 32'hDEAD_BEEF, 0, 1, 0};
        tbl[4] = '{3, 1'b0, 32'h0000_1000, 32'h0,          2, 5, 0};
        tbl[5] = '{0, 1'b1, 32'h0000_0FFC, 32'h1234_5678, 1, 1, 1};

        // Reset
        rst = 1'b1;
        slave_read = '0; slave_write = '0;
        slave_address = '0; slave_writedata = '0;
        master_waitrequest = 1'b0;
        master_readdatavalid = 1'b0;
        master_readdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_waitreq", slave_waitrequest, 4'hF);
        chk("rst_rdv", slave_readdatavalid, 4'h0);
        chk("rst_mread", master_read, 1'b0);
        chk("rst_mwrite", master_write, 1'b0);
        chk("rst_addr", master_address, 32'hFFFF_FFFF);
        chk("rst_state", dbg_state, IDLE);
        chk("rst_ptr", dbg_ptr, 2'd0);
        chk("rst_grant", dbg_grant, 2'd0);
        chk("rst_terr", timeout_err, 1'b0);
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Contention: 0,1,3 together from ptr 0
        push_acc(0, 1'b0, addr_of(0), 32'h0); push_exp(0, model_data(addr_of(0)));
        push_acc(1, 1'b0, addr_of(1), 32'h0); push_exp(1, model_data(addr_of(1)));
        push_acc(3, 1'b0, addr_of(3), 32'h0); push_exp(3, model_data(addr_of(3)));
        run_multi(1, 1, 0, 1, 2);
        chk("contention_ptr", dbg_ptr, 2'd0);

        // Fairness: requester 0 keeps requesting, requester 2 must get in next
        push_acc(0, 1'b0, addr_of(0), 32'h0); push_exp(0, model_data(addr_of(0)));
        push_acc(2, 1'b0, addr_of(2), 32'h0); push_exp(2, model_data(addr_of(2)));
        push_acc(0, 1'b0, addr_of(0), 32'h0); push_exp(0, model_data(addr_of(0)));
        run_multi(2, 0, 1, 0, 1);
        chk("fairness_ptr", dbg_ptr, 2'd1);

        // Table of single transactions
        for (int t = 0; t < 6; t++) begin
            run_txn(tbl[t]);
            chk($sformatf("tbl%0d_ptr", t), dbg_ptr, 64'(tbl[t].exp_ptr));
        end

        // Reset while a read is outstanding; the late response must vanish
        rd_lat = 3;
        push_acc(2, 1'b0, 32'h200, 32'h0);
        slave_address[2*32 +: 32] = 32'h200;
        slave_read[2] = 1'b1;
        hit = 1'b0;
        for (int c = 0; c < 20 && !hit; c++) begin
            @(posedge clk); #1;
            if (dbg_state == WAIT_RD) hit = 1'b1;
        end
        if (!hit) flag_fail("rstrd_reach_wait");
        rst = 1'b1;
        slave_read = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("rstrd_state", dbg_state, IDLE);
        chk("rstrd_ptr", dbg_ptr, 2'd0);
        chk("rstrd_rdv", slave_readdatavalid, 4'h0);
        chk("rstrd_terr", timeout_err, 1'b0);
        @(posedge clk); #1;

`ifdef ARB_TIMEOUT_EN
        // Watchdog: no return for 16 WAIT_RD cycles, late return then dropped
        rd_lat = 25;
        push_acc(3, 1'b0, 32'h300, 32'h0);
        push_exp(3, 32'hFFFF_FFFF);
        slave_address[3*32 +: 32] = 32'h300;
        slave_read[3] = 1'b1;
        wcnt = 0;
        hit  = 1'b0;
        for (int c = 0; c < 100 && !hit; c++) begin
            @(negedge clk);
            if (dbg_state == WAIT_RD) wcnt++;
            if (slave_readdatavalid[3]) hit = 1'b1;
            @(posedge clk); #1;
        end
        if (!hit) flag_fail("tmo_no_response");
        chk("tmo_wait_cycles", 64'(wcnt), 64'd16);
        slave_read = '0;
        chk("tmo_err_set", timeout_err, 1'b1);
        repeat (2) begin @(posedge clk); #1; end
        run_txn('{1, 1'b0, 32'h0000_0140, 32'h0, 0, 10, 2});
        chk("tmo_err_sticky", timeout_err, 1'b1);
`else
        chk("terr_tied", timeout_err, 1'b0);
`endif

        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        chk("acc_q_drained", 64'(acc_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of move-generator masters sharing one SDRAM port.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024: read-response timeout; used only when ARB_TIMEOUT_EN is defined.
REQ-003 Ports, in order:
- clk  in  1  clock.
- rst  in  1  reset; one clock, synchronous, active-high.
- slave_read  in  NUM_REQ  per-requester read strobe.
- slave_write  in  NUM_REQ  per-requester write strobe.
- slave_address  in  NUM_REQ*32  packed; requester i occupies bits [i*32 +: 32].
- slave_writedata  in  NUM_REQ*32  packed, same layout.
- slave_waitrequest  out  NUM_REQ  per-requester stall.
- slave_readdatavalid  out  NUM_REQ  per-requester read return.
- slave_readdata  out  32  shared read data.
- master_waitrequest  in  1  SDRAM stall.
- master_address  out  32  SDRAM address.
- master_read  out  1  SDRAM read strobe.
- master_write  out  1  SDRAM write strobe.
- master_writedata  out  32  SDRAM write data.
- master_readdata  in  32  SDRAM read data.
- master_readdatavalid  in  1  SDRAM read return.
- timeout_err  out  1  sticky timeout flag.

Function
REQ-004 The FSM SHALL have states IDLE, ISSUE, WAIT_RD and RELEASE.
REQ-005 IDLE: if any requester asserts read or write, the FSM SHALL latch grant g from the round-robin picker and go to ISSUE; otherwise it SHALL stay in IDLE. Arbitration latency is 1 cycle.
REQ-006 Round-robin: search starts at ptr and wraps modulo NUM_REQ. The first active requester is selected.
REQ-007 RELEASE SHALL set ptr = (g+1) mod NUM_REQ, then return to IDLE.
REQ-008 ISSUE SHALL drive master_address and master_writedata from the slice of requester g.
- master_write = slave_write[g].
- master_read = slave_read[g] and not slave_write[g]; write wins if both are asserted.
REQ-009 ISSUE with master_waitrequest=0:
- Write: slave_waitrequest[g]=0 in that cycle, then RELEASE.
- Read: go to WAIT_RD.
- Strobe dropped by the requester: go to RELEASE with no SDRAM access.
REQ-010 WAIT_RD SHALL hold master_read=0. On master_readdatavalid=1 it SHALL assert slave_readdatavalid[g] for exactly that cycle, then go to RELEASE.
REQ-011 slave_readdata SHALL equal master_readdata combinationally, except in the timeout case (REQ-017).
REQ-012 Only one SDRAM transaction is outstanding at a time. A read request held high SHALL produce exactly one master_read acceptance.
REQ-013 Outside ISSUE, all slave_waitrequest bits SHALL be 1, except the grant bit on a write acceptance.
- slave_readdatavalid bits SHALL be 0 except per REQ-010.
- master_read and master_write SHALL be 0.
- master_address and master_writedata SHALL be 32'hFFFFFFFF.
REQ-014 master_readdatavalid arriving outside WAIT_RD SHALL be ignored.

Reset
REQ-015 rst SHALL force all of the following on the next edge, aborting any transaction in flight:
- state=IDLE, ptr=0, g=0.
- timeout_err=0, timeout counter=0.
- all slave_waitrequest=1, all slave_readdatavalid=0.
- master_read=0, master_write=0.
A pending SDRAM response after reset SHALL be discarded per REQ-014.

Configuration
REQ-016 Macro ARB_TIMEOUT_EN SHALL compile the read watchdog in or out.
REQ-017 With ARB_TIMEOUT_EN defined, the counter SHALL clear on entry to WAIT_RD and increment each WAIT_RD cycle. When it reaches TIMEOUT_CYCLES-1 without a return:
- assert slave_readdatavalid[g] with slave_readdata=32'hFFFFFFFF;
- set timeout_err;
- set a drop flag that discards the next master_readdatavalid;
- go to RELEASE.
REQ-018 Without ARB_TIMEOUT_EN, WAIT_RD SHALL wait indefinitely and timeout_err SHALL be tied 0.

Structure
REQ-019 Package arb_pkg SHALL hold:
- the state enum;
- NUM_REQ_DEFAULT=4;
- WORD_INVALID=32'hFFFFFFFF.
REQ-020 The combinational round-robin picker SHALL be sub-module rr_picker (inputs req vector and ptr; outputs grant index and any-valid).

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Single read, no contention: slave_read[2]=1, address 0x100, SDRAM returns 0x0000002A after 3 cycles. Required: one master_read with master_address=0x100, slave_readdatavalid[2] pulses once, slave_readdata=0x2A.
- Contention: reads from 0,1,3 asserted together at ptr=0. Required: grants in order 0,1,3, then ptr=0 again; no overlap of SDRAM strobes.
- Write with stall: slave_write[1]=1, address 0x40, data 0x05, master_waitrequest high for 4 cycles. Required: slave_waitrequest[1] falls only in the cycle master_waitrequest=0; exactly one SDRAM write.
- Fairness: requester 0 re-requests continuously while requester 2 waits. Required: requester 2 is granted after at most one requester-0 transaction.
- Reset mid-read: rst in WAIT_RD, late master_readdatavalid 2 cycles after reset. Required: no slave_readdatavalid, state IDLE, ptr=0.
- ARB_TIMEOUT_EN with TIMEOUT_CYCLES=16 and no SDRAM return: slave_readdatavalid[g] in WAIT_RD cycle 16 with data 0xFFFFFFFF, timeout_err=1; a late return is dropped.
